// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port, with a bounded ready wait, an illegal-opcode trap and a retire counter.
module multicycle_control_fsm #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4,
    parameter int RET_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             addr_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       imm_sel,
    output logic [1:0]       alu_op,
    output logic             alu_src1,
    output logic             alu_src2,
    output logic             is_rtype,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             retire,
    output logic [RET_W-1:0] retired,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [2:0]       state
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT);

    typedef struct packed {
        logic       legal;
        logic [2:0] imm_sel;
        logic [1:0] alu_op;
        logic       alu_src1;
        logic       alu_src2;
        logic       is_rtype;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] op);
        dec_t d;
        d       = '0;
        d.legal = 1'b1;
        case (op)
            OP_R:      begin d.alu_op = 2'd3; d.is_rtype = 1'b1; end
            OP_I:      begin d.imm_sel = 3'd1; d.alu_op = 2'd3; d.alu_src2 = 1'b1; end
            OP_LOAD,
            OP_JALR:   begin d.imm_sel = 3'd1; d.alu_op = 2'd2; d.alu_src2 = 1'b1; end
            OP_STORE:  begin d.imm_sel = 3'd2; d.alu_op = 2'd2; d.alu_src2 = 1'b1; end
            OP_BRANCH: begin d.imm_sel = 3'd3; d.alu_op = 2'd1; end
            OP_JAL:    d.imm_sel = 3'd5;
            OP_LUI:    d.imm_sel = 3'd4;
            OP_AUIPC:  begin
                d.imm_sel = 3'd4; d.alu_op = 2'd2; d.alu_src1 = 1'b1; d.alu_src2 = 1'b1;
            end
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic [1:0]       fcode_q, fcode_d;

    // DECODE looks at the live IR opcode; later states use the latched copy.
    dec_t dec;
    assign dec = decode((state_q == S_DECODE) ? opcode : op_q);

    logic            req, timeout_hit;
    logic [TO_W:0]   wait_inc;
    assign req         = (state_q == S_FETCH) || (state_q == S_MEM);
    assign wait_inc    = {1'b0, wait_q} + (TO_W+1)'(1);
    assign timeout_hit = (TIMEOUT != 0) && req && !mem_ready && (wait_inc == TO_LIM);

    always_comb begin
        ir_write  = 1'b0;
        addr_sel  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        imm_sel   = 3'd0;
        alu_op    = 2'd0;
        alu_src1  = 1'b0;
        alu_src2  = 1'b0;
        is_rtype  = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        retire    = 1'b0;
        fault     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                S_DECODE: imm_sel = dec.imm_sel;
                S_EXEC, S_WB: begin
                    imm_sel  = dec.imm_sel;
                    alu_op   = dec.alu_op;
                    alu_src1 = dec.alu_src1;
                    alu_src2 = dec.alu_src2;
                    is_rtype = dec.is_rtype;
                    if (state_q == S_WB) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        case (op_q)
                            OP_R, OP_I, OP_AUIPC: reg_write = 1'b1;
                            OP_LOAD:   begin reg_write = 1'b1; wb_sel = 2'd1; end
                            OP_JAL:    begin reg_write = 1'b1; wb_sel = 2'd2; pc_src = 2'd1; end
                            OP_JALR:   begin reg_write = 1'b1; wb_sel = 2'd2; pc_src = 2'd2; end
                            OP_LUI:    begin reg_write = 1'b1; wb_sel = 2'd3; end
                            OP_BRANCH: pc_src = branch_taken ? 2'd1 : 2'd0;
                            default: ;
                        endcase
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (op_q == OP_STORE);
                    // A store has no WB stage, so it retires when the write lands.
                    if (mem_ready && op_q == OP_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign state      = state_q;
    assign fault_code = fcode_q;
    assign retired    = retired_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        fcode_d   = fcode_q;
        retired_d = retire ? retired_q + RET_W'(1) : retired_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                    fcode_d = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (dec.legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FAULT;
                    fcode_d = FC_ILLEGAL;
                end
            end
            S_EXEC: state_d = (op_q == OP_LOAD || op_q == OP_STORE) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                    fcode_d = FC_TIMEOUT;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase

        wait_d = wait_q;
        if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) begin
            wait_d = '0;
        end else if (req && !mem_ready) begin
            wait_d = wait_inc[TO_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            fcode_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            fcode_q   <= fcode_d;
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each instruction is expanded into its expected
// per-cycle trace from the decode table, then replayed and compared cycle by cycle.
module tb_multicycle_control_fsm;
    localparam int TO = 15;
    localparam int RW = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic clk = 1'b0;
    logic rst, branch_taken, mem_ready;
    logic [6:0] opcode;
    logic ir_write, addr_sel, mem_req, mem_we, alu_src1, alu_src2, is_rtype;
    logic reg_write, pc_write, retire, fault;
    logic [2:0] imm_sel, state;
    logic [1:0] alu_op, wb_sel, pc_src, fault_code;
    logic [RW-1:0] retired;

    multicycle_control_fsm #(.TIMEOUT(TO), .TO_W(4), .RET_W(RW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .ir_write(ir_write), .addr_sel(addr_sel),
        .mem_req(mem_req), .mem_we(mem_we), .imm_sel(imm_sel), .alu_op(alu_op),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .is_rtype(is_rtype),
        .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
        .retire(retire), .retired(retired), .fault(fault), .fault_code(fault_code),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic ir_write, addr_sel, mem_req, mem_we;
        logic [2:0] imm_sel;
        logic [1:0] alu_op;
        logic alu_src1, alu_src2, is_rtype, reg_write;
        logic [1:0] wb_sel;
        logic pc_write;
        logic [1:0] pc_src;
        logic retire, fault;
        logic [1:0] fault_code;
        logic [RW-1:0] retired;
    } outs_t;

    typedef struct packed {
        logic legal;
        logic [2:0] imm;
        logic [1:0] alu;
        logic s1, s2, rt, rw;
        logic [1:0] wb, pcs;
        logic mem, st, br;
    } row_t;

    typedef struct {
        logic rdy;
        logic [6:0] op;
        logic bt;
        outs_t exp;
    } rec_t;

    rec_t q[$];
    int compared = 0;
    int mismatched = 0;
    int ret = 0;
    logic [6:0] legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                  OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    function automatic row_t mk(int lg, int imm, int alu, int s1, int s2, int rt,
                                int rw, int wb, int pcs, int mem, int st, int br);
        row_t r;
        r.legal = 1'(lg); r.imm = 3'(imm); r.alu = 2'(alu);
        r.s1 = 1'(s1); r.s2 = 1'(s2); r.rt = 1'(rt); r.rw = 1'(rw);
        r.wb = 2'(wb); r.pcs = 2'(pcs); r.mem = 1'(mem); r.st = 1'(st); r.br = 1'(br);
        return r;
    endfunction

    // Control table: legal imm alu src1 src2 rtype | regw wb pcsrc | mem store branch
    function automatic row_t row(input logic [6:0] op);
        case (op)
            OP_R:      return mk(1, 0, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0);
            OP_I:      return mk(1, 1, 3, 0, 1, 0, 1, 0, 0, 0, 0, 0);
            OP_LOAD:   return mk(1, 1, 2, 0, 1, 0, 1, 1, 0, 1, 0, 0);
            OP_STORE:  return mk(1, 2, 2, 0, 1, 0, 0, 0, 0, 1, 1, 0);
            OP_BRANCH: return mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            OP_JAL:    return mk(1, 5, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0);
            OP_JALR:   return mk(1, 1, 2, 0, 1, 0, 1, 2, 2, 0, 0, 0);
            OP_LUI:    return mk(1, 4, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
            OP_AUIPC:  return mk(1, 4, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0);
            default:   return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    function automatic outs_t base(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.state = st;
        o.retired = RW'(ret);
        return o;
    endfunction

    function automatic outs_t with_alu(input outs_t o, input row_t r);
        outs_t x;
        x = o;
        x.imm_sel = r.imm; x.alu_op = r.alu;
        x.alu_src1 = r.s1; x.alu_src2 = r.s2; x.is_rtype = r.rt;
        return x;
    endfunction

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic push(input logic rdy, input logic [6:0] op, input logic bt, input outs_t o);
        rec_t r;
        r.rdy = rdy; r.op = op; r.bt = bt; r.exp = o;
        q.push_back(r);
    endtask

    task automatic push_fault(input int code, input int n);
        outs_t o;
        for (int i = 0; i < n; i++) begin
            o = base(3'd7);
            o.fault = 1'b1;
            o.fault_code = 2'(code);
            push(rbit(), junk(), rbit(), o);
        end
    endtask

    // Appends the expected cycle trace of one instruction: fw/mw are the number of
    // not-ready cycles before the fetch / data access completes.
    task automatic build(input logic [6:0] op, input int fw, input int mw, input logic bt);
        row_t r;
        outs_t o;
        r = row(op);
        for (int i = 0; i < fw && i < TO; i++) begin
            o = base(3'd0); o.mem_req = 1'b1;
            push(1'b0, junk(), rbit(), o);
        end
        if (fw >= TO) begin push_fault(2, 5); return; end
        o = base(3'd0); o.mem_req = 1'b1; o.ir_write = 1'b1;
        push(1'b1, junk(), rbit(), o);
        o = base(3'd1); o.imm_sel = r.imm;
        push(rbit(), op, rbit(), o);
        if (!r.legal) begin push_fault(1, 20); return; end
        push(rbit(), junk(), rbit(), with_alu(base(3'd2), r));
        if (r.mem) begin
            for (int i = 0; i < mw && i < TO; i++) begin
                o = base(3'd3); o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = r.st;
                push(1'b0, junk(), rbit(), o);
            end
            if (mw >= TO) begin push_fault(2, 5); return; end
            o = base(3'd3); o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = r.st;
            o.pc_write = r.st; o.retire = r.st;
            push(1'b1, junk(), rbit(), o);
            if (r.st) begin ret = (ret + 1) % (1 << RW); return; end
        end
        o = with_alu(base(3'd4), r);
        o.reg_write = r.rw; o.wb_sel = r.wb; o.pc_write = 1'b1; o.retire = 1'b1;
        o.pc_src = r.br ? {1'b0, bt} : r.pcs;
        push(rbit(), junk(), bt, o);
        ret = (ret + 1) % (1 << RW);
    endtask

    function automatic outs_t sample();
        outs_t a;
        a.state = state; a.ir_write = ir_write; a.addr_sel = addr_sel; a.mem_req = mem_req;
        a.mem_we = mem_we; a.imm_sel = imm_sel; a.alu_op = alu_op; a.alu_src1 = alu_src1;
        a.alu_src2 = alu_src2; a.is_rtype = is_rtype; a.reg_write = reg_write;
        a.wb_sel = wb_sel; a.pc_write = pc_write; a.pc_src = pc_src; a.retire = retire;
        a.fault = fault; a.fault_code = fault_code; a.retired = retired;
        return a;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: outputs got %h want %h (state got %0d want %0d)",
                     name, $time, act, exp, act.state, exp.state);
        end
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // The single compare process: replays the queued trace, one record per cycle.
    task automatic run_q();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            mem_ready = r.rdy; opcode = r.op; branch_taken = r.bt;
            #1;
            check("trace", r.exp);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = rbit(); opcode = junk();
        #1 check("reset_async", '0);
        @(negedge clk);
        #1 check("reset_hold", '0);
        rst = 1'b0; mem_ready = 1'b0;
        ret = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        rst = 1'b1; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        do_reset();

        build(OP_I, 0, 0, 1'b0);
        check_lit("addi_cycles", q.size(), 4);
        check_lit("addi_states", int'({q[0].exp.state, q[1].exp.state, q[2].exp.state,
                                       q[3].exp.state}), 12'h054);
        run_q();
        check_lit("addi_retired", int'(retired), 1);

        build(OP_LOAD, 3, 3, 1'b0);
        check_lit("lw_cycles", q.size(), 11);
        run_q();

        build(OP_STORE, 1, 2, 1'b0);
        build(OP_BRANCH, 0, 0, 1'b1);
        build(OP_BRANCH, 0, 0, 1'b0);
        build(OP_JAL, 0, 0, 1'b1);
        build(OP_JALR, 2, 0, 1'b0);
        build(OP_LUI, 0, 0, 1'b0);
        build(OP_AUIPC, 0, 0, 1'b1);
        build(OP_R, 1, 0, 1'b0);
        build(OP_I, TO - 1, 0, 1'b0);
        build(OP_LOAD, 0, TO - 1, 1'b0);
        build(OP_STORE, TO - 1, TO - 1, 1'b0);
        run_q();
        check_lit("no_fault_at_limit", int'(fault), 0);

        for (int n = 0; n < 80; n++) begin
            build(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 4),
                  $urandom_range(0, 4), rbit());
        end
        run_q();

        do_reset();
        for (int n = 0; n < 17; n++) build(OP_I, 0, 0, 1'b0);
        run_q();
        check_lit("retired_wrap", int'(retired), 1);

        build(7'b1111111, 0, 0, 1'b0);
        run_q();
        check_lit("illegal_code", int'(fault_code), 1);
        check_lit("illegal_req", int'(mem_req), 0);

        do_reset();
        build(OP_I, TO, 0, 1'b0);
        run_q();
        check_lit("fetch_timeout_code", int'(fault_code), 2);

        do_reset();
        build(OP_LOAD, 0, TO, 1'b0);
        run_q();
        check_lit("mem_timeout_code", int'(fault_code), 2);

        do_reset();
        op = junk();
        while (row(op).legal) op = junk();
        build(op, $urandom_range(0, 5), 0, 1'b0);
        run_q();
        check_lit("rand_illegal_code", int'(fault_code), 1);

        // Abandon a store mid-access: keep only FETCH..EXEC and two MEM wait cycles.
        do_reset();
        build(OP_STORE, 0, 3, 1'b0);
        void'(q.pop_back());
        void'(q.pop_back());
        run_q();
        check_lit("sw_in_mem", int'(state), 3);
        do_reset();
        build(OP_I, 0, 0, 1'b0);
        run_q();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
